// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CODE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON_PH  = 2'd1,
        OFF_PH = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: OFF/ON/BLINK/CODE state machine advanced by the shared pattern tick.
module led_pattern_chan
    import led_pattern_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int COUNT_W    = 4,
    parameter int GAP_HALVES = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                tick,
    input  mode_t               mode,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [COUNT_W-1:0]  blink_count,
    output logic                pattern
);

    localparam int GAP_W = PERIOD_W + 3;

    state_t              state_q, state_d;
    mode_t               mode_q;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [COUNT_W-1:0]  blinks_q, blinks_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                pat_d;

    logic [PERIOD_W-1:0] hp;
    logic [GAP_W-1:0]    gap_lim;
    logic [COUNT_W:0]    blinks_nx;
    logic                phase_end, gap_end, code_done;

    assign hp        = (half_period == '0) ? PERIOD_W'(1) : half_period;
    // >= rather than == so a half-period shrunk mid-phase ends the phase at the next tick
    assign phase_end = (phase_q >= hp - PERIOD_W'(1));
    assign gap_lim   = GAP_W'(GAP_HALVES) * GAP_W'(hp) - GAP_W'(1);
    assign gap_end   = (gap_q >= gap_lim);
    assign blinks_nx = {1'b0, blinks_q} + (COUNT_W+1)'(1);
    assign code_done = (blinks_nx >= {1'b0, blink_count});

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        blinks_d = blinks_q;
        gap_d    = gap_q;
        pat_d    = pattern;
        if (mode != mode_q) begin
            phase_d  = '0;
            blinks_d = '0;
            gap_d    = '0;
            case (mode)
                MODE_OFF:   begin state_d = IDLE;  pat_d = 1'b0; end
                MODE_ON:    begin state_d = IDLE;  pat_d = 1'b1; end
                MODE_BLINK: begin state_d = ON_PH; pat_d = 1'b1; end
                default: begin
                    if (blink_count == '0) begin
                        state_d = GAP;
                        pat_d   = 1'b0;
                    end else begin
                        state_d = ON_PH;
                        pat_d   = 1'b1;
                    end
                end
            endcase
        end else if (tick) begin
            case (state_q)
                ON_PH: begin
                    if (phase_end) begin
                        phase_d = '0;
                        state_d = OFF_PH;
                        pat_d   = 1'b0;
                    end else begin
                        phase_d = phase_q + PERIOD_W'(1);
                    end
                end
                OFF_PH: begin
                    if (phase_end) begin
                        phase_d = '0;
                        if (mode == MODE_CODE) begin
                            blinks_d = blinks_nx[COUNT_W-1:0];
                            if (code_done) begin
                                state_d = GAP;
                                pat_d   = 1'b0;
                            end else begin
                                state_d = ON_PH;
                                pat_d   = 1'b1;
                            end
                        end else begin
                            state_d = ON_PH;
                            pat_d   = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PERIOD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        gap_d    = '0;
                        blinks_d = '0;
                        // a zero count keeps the channel parked dark in GAP
                        if (blink_count != '0) begin
                            state_d = ON_PH;
                            pat_d   = 1'b1;
                        end
                    end else if (gap_q != {GAP_W{1'b1}}) begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            mode_q   <= MODE_OFF;
            phase_q  <= '0;
            blinks_q <= '0;
            gap_q    <= '0;
            pattern  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode;
            phase_q  <= phase_d;
            blinks_q <= blinks_d;
            gap_q    <= gap_d;
            pattern  <= pat_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel status-LED driver: shared tick prescaler plus NUM_LEDS pattern channels.
// Optional LED_PWM_DIM_EN adds a BRIGHTNESS port and a shared 8-bit PWM dimmer.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1000,
    parameter int PERIOD_W   = 16,
    parameter int COUNT_W    = 4,
    parameter int GAP_HALVES = 4
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [2*NUM_LEDS-1:0]        MODE,
    input  logic [PERIOD_W*NUM_LEDS-1:0] HALF_PERIOD,
    input  logic [COUNT_W*NUM_LEDS-1:0]  BLINK_COUNT,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_W*NUM_LEDS-1:0]    BRIGHTNESS,
`endif
    output logic [NUM_LEDS-1:0]          LED
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0]    pre_cnt;
    logic                tick;
    logic [NUM_LEDS-1:0] pattern;

    // free-running; mode changes never realign it
    assign tick = (pre_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (!RESETN)   pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + DIV_W'(1);
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_pattern_chan #(
            .PERIOD_W  (PERIOD_W),
            .COUNT_W   (COUNT_W),
            .GAP_HALVES(GAP_HALVES)
        ) u_chan (
            .CLK        (CLK),
            .RESETN     (RESETN),
            .tick       (tick),
            .mode       (mode_t'(MODE[2*i +: 2])),
            .half_period(HALF_PERIOD[PERIOD_W*i +: PERIOD_W]),
            .blink_count(BLINK_COUNT[COUNT_W*i +: COUNT_W]),
            .pattern    (pattern[i])
        );
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pwm_cnt <= '0;
            LED     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            for (int i = 0; i < NUM_LEDS; i++)
                LED[i] <= pattern[i] & (pwm_cnt < BRIGHTNESS[PWM_W*i +: PWM_W]);
        end
    end
`else
    assign LED = pattern;
`endif

endmodule
